// File: rtl/prog_alu_sequencer.sv
// prog_alu_sequencer: a loadable program memory stepped by a fetch/execute/writeback
// FSM. Each instruction drives a WIDTH-bit ALU that feeds an accumulator and
// {N,C,Z} flags. The FSM also handles jumps, halt, illegal-opcode detection and
// a step watchdog.
module prog_alu_sequencer #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int MAX_STEPS = 255
) (
  input  logic                       fast_clk,
  input  logic                       rst,
  input  logic                       prog_we,
  input  logic [$clog2(DEPTH)-1:0]   prog_addr,
  input  logic [5+2*WIDTH-1:0]       prog_data,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [1:0]                 err,
  output logic [$clog2(DEPTH)-1:0]   pc,
  output logic [WIDTH-1:0]           in_a,
  output logic [WIDTH-1:0]           in_b,
  output logic [4:0]                 opcode,
  output logic [WIDTH-1:0]           res,
  output logic [2:0]                 flags,
  output logic [7:0]                 steps,
  output logic                       led
);
  localparam int AW = $clog2(DEPTH);
  localparam int IW = 5 + 2*WIDTH;
  localparam logic [31:0] MAX_STEPS_U = MAX_STEPS;

  localparam logic [4:0] OP_NOP  = 5'd0;
  localparam logic [4:0] OP_ADD  = 5'd1;
  localparam logic [4:0] OP_SUB  = 5'd2;
  localparam logic [4:0] OP_AND  = 5'd3;
  localparam logic [4:0] OP_OR   = 5'd4;
  localparam logic [4:0] OP_XOR  = 5'd5;
  localparam logic [4:0] OP_NOT  = 5'd6;
  localparam logic [4:0] OP_SHL  = 5'd7;
  localparam logic [4:0] OP_SHR  = 5'd8;
  localparam logic [4:0] OP_CMP  = 5'd9;
  localparam logic [4:0] OP_ACC  = 5'd10;
  localparam logic [4:0] OP_JZ   = 5'd11;
  localparam logic [4:0] OP_JNZ  = 5'd12;
  localparam logic [4:0] OP_JMP  = 5'd13;
  localparam logic [4:0] OP_HALT = 5'd31;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_WB, S_HALT} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     pc_q, pc_d;
  logic [WIDTH-1:0]  in_a_q, in_a_d, in_b_q, in_b_d;
  logic [4:0]        opcode_q, opcode_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic [2:0]        flags_q, flags_d;
  logic [7:0]        steps_q, steps_d;
  logic [1:0]        err_q, err_d;
  logic              done_q, done_d;
  logic              led_q, led_d;
  logic [WIDTH-1:0]  alu_res_q, alu_res_d;
  logic              alu_c_q, alu_c_d;

  logic [IW-1:0]     mem [DEPTH];
  logic [IW-1:0]     instr;
  logic [WIDTH-1:0]  alu_r;
  logic              alu_c;
  logic [WIDTH:0]    wide;
  logic [7:0]        steps_inc;
  logic              legal;
  logic              taken;

  assign instr = mem[pc_q];
  assign busy  = (state_q == S_FETCH) || (state_q == S_EXEC) || (state_q == S_WB);
  assign legal = (opcode_q <= OP_JMP) || (opcode_q == OP_HALT);

  // Program memory: written only while the sequencer is parked; never reset.
  always_ff @(posedge fast_clk) begin
    if (prog_we && !busy) mem[prog_addr] <= prog_data;
  end

  // ALU: result and carry/borrow for the currently latched instruction.
  always_comb begin
    alu_r = '0;
    alu_c = 1'b0;
    wide  = '0;
    case (opcode_q)
      OP_ADD: begin
        wide  = {1'b0, in_a_q} + {1'b0, in_b_q};
        alu_r = wide[WIDTH-1:0];
        alu_c = wide[WIDTH];
      end
      OP_SUB, OP_CMP: begin
        wide  = {1'b0, in_a_q} - {1'b0, in_b_q};
        alu_r = wide[WIDTH-1:0];
        alu_c = wide[WIDTH];
      end
      OP_AND: alu_r = in_a_q & in_b_q;
      OP_OR:  alu_r = in_a_q | in_b_q;
      OP_XOR: alu_r = in_a_q ^ in_b_q;
      OP_NOT: alu_r = ~in_a_q;
      OP_SHL: begin
        // Extra top bit catches the last bit shifted out.
        wide  = {1'b0, in_a_q} << in_b_q[2:0];
        alu_r = wide[WIDTH-1:0];
        alu_c = wide[WIDTH];
      end
      OP_SHR: begin
        // Extra bottom bit catches the last bit shifted out.
        wide  = {in_a_q, 1'b0} >> in_b_q[2:0];
        alu_r = wide[WIDTH:1];
        alu_c = wide[0];
      end
      OP_ACC: begin
        wide  = {1'b0, res_q} + {1'b0, in_a_q};
        alu_r = wide[WIDTH-1:0];
        alu_c = wide[WIDTH];
      end
      default: begin
        alu_r = '0;
        alu_c = 1'b0;
      end
    endcase
  end

  // Sequencer next-state: fetch, execute, writeback, halt and watchdog.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    in_a_d    = in_a_q;
    in_b_d    = in_b_q;
    opcode_d  = opcode_q;
    res_d     = res_q;
    flags_d   = flags_q;
    steps_d   = steps_q;
    err_d     = err_q;
    alu_res_d = alu_res_q;
    alu_c_d   = alu_c_q;
    steps_inc = (steps_q == 8'hFF) ? steps_q : steps_q + 8'd1;
    taken     = (opcode_q == OP_JMP) ||
                ((opcode_q == OP_JZ)  &&  flags_q[0]) ||
                ((opcode_q == OP_JNZ) && !flags_q[0]);
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = '0;
          res_d   = '0;
          flags_d = '0;
          steps_d = '0;
          err_d   = 2'd0;
        end
      end
      S_FETCH: begin
        opcode_d = instr[IW-1 -: 5];
        in_a_d   = instr[2*WIDTH-1 -: WIDTH];
        in_b_d   = instr[WIDTH-1:0];
        state_d  = S_EXEC;
      end
      S_EXEC: begin
        if (legal) begin
          alu_res_d = alu_r;
          alu_c_d   = alu_c;
          state_d   = S_WB;
        end else begin
          err_d   = 2'd1;
          state_d = S_HALT;
        end
      end
      S_WB: begin
        steps_d = steps_inc;
        if (((opcode_q >= OP_ADD) && (opcode_q <= OP_SHR)) || (opcode_q == OP_ACC)) begin
          res_d = alu_res_q;
        end
        if (((opcode_q >= OP_ADD) && (opcode_q <= OP_ACC))) begin
          flags_d = {alu_res_q[WIDTH-1], alu_c_q, (alu_res_q == '0)};
        end
        if (opcode_q == OP_HALT) begin
          state_d = S_HALT;
        end else begin
          pc_d = taken ? in_a_q[AW-1:0] : pc_q + AW'(1);
          if ({24'd0, steps_inc} >= MAX_STEPS_U) begin
            err_d   = 2'd2;
            state_d = S_HALT;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    done_d = (state_d == S_HALT) && (state_q != S_HALT);
    led_d  = led_q ^ done_d;
  end

  // State and datapath registers; reset aborts a run with no done pulse.
  always_ff @(posedge fast_clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      in_a_q    <= '0;
      in_b_q    <= '0;
      opcode_q  <= '0;
      res_q     <= '0;
      flags_q   <= '0;
      steps_q   <= '0;
      err_q     <= 2'd0;
      done_q    <= 1'b0;
      led_q     <= 1'b0;
      alu_res_q <= '0;
      alu_c_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      in_a_q    <= in_a_d;
      in_b_q    <= in_b_d;
      opcode_q  <= opcode_d;
      res_q     <= res_d;
      flags_q   <= flags_d;
      steps_q   <= steps_d;
      err_q     <= err_d;
      done_q    <= done_d;
      led_q     <= led_d;
      alu_res_q <= alu_res_d;
      alu_c_q   <= alu_c_d;
    end
  end

  assign done   = done_q;
  assign err    = err_q;
  assign pc     = pc_q;
  assign in_a   = in_a_q;
  assign in_b   = in_b_q;
  assign opcode = opcode_q;
  assign res    = res_q;
  assign flags  = flags_q;
  assign steps  = steps_q;
  assign led    = led_q;
endmodule

// File: tb/tb_prog_alu_sequencer.sv
// Directed testbench for prog_alu_sequencer (WIDTH=8, DEPTH=16, MAX_STEPS=10).
module tb_prog_alu_sequencer;
  localparam int W  = 8;
  localparam int D  = 16;
  localparam int MS = 10;
  localparam int AW = 4;
  localparam int IW = 5 + 2*W;

  logic          fast_clk = 1'b0;
  logic          rst = 1'b1;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [IW-1:0] prog_data = '0;
  logic          start = 1'b0;
  logic          busy, done, led;
  logic [1:0]    err;
  logic [AW-1:0] pc;
  logic [W-1:0]  in_a, in_b, res;
  logic [4:0]    opcode;
  logic [2:0]    flags;
  logic [7:0]    steps;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic exp_led  = 1'b0;

  prog_alu_sequencer #(.WIDTH(W), .DEPTH(D), .MAX_STEPS(MS)) dut (
    .fast_clk(fast_clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .start(start), .busy(busy), .done(done), .err(err),
    .pc(pc), .in_a(in_a), .in_b(in_b), .opcode(opcode), .res(res),
    .flags(flags), .steps(steps), .led(led)
  );

  always #5 fast_clk = ~fast_clk;

  function automatic logic [IW-1:0] ins(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b);
    return {op, a, b};
  endfunction

  task automatic load(input logic [AW-1:0] addr, input logic [IW-1:0] data);
    prog_we = 1'b1; prog_addr = addr; prog_data = data;
    @(posedge fast_clk); #1;
    prog_we = 1'b0;
  endtask

  // Pulse start, then count cycles until done (bounded); cyc=-1 on timeout.
  task automatic run(output int cyc);
    start = 1'b1;
    @(posedge fast_clk); #1;
    start = 1'b0;
    cyc = -1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge fast_clk); #1;
      if (done === 1'b1) begin cyc = i; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge fast_clk);
    #1 rst = 1'b0;
    #1;
    n_checks++; if ({pc, in_a, in_b, opcode, res, flags, steps, err, done, led} !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h required 0", {pc, in_a, in_b, opcode, res, flags, steps, err, done, led}); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
  endtask

  task automatic test_add();
    int cyc;
    load(0, ins(5'd1, 8'h05, 8'h03));
    load(1, ins(5'd31, 8'h00, 8'h00));
    run(cyc);
    exp_led = ~exp_led;
    n_checks++; if (cyc !== 6)       begin n_fail++; $display("FAIL add_cycles: got %0d required 6", cyc); end
    n_checks++; if (res !== 8'h08)   begin n_fail++; $display("FAIL add_res: got %h required 08", res); end
    n_checks++; if (flags !== 3'b000) begin n_fail++; $display("FAIL add_flags: got %b required 000", flags); end
    n_checks++; if (err !== 2'd0)    begin n_fail++; $display("FAIL add_err: got %0d required 0", err); end
    n_checks++; if (steps !== 8'd2)  begin n_fail++; $display("FAIL add_steps: got %0d required 2", steps); end
    n_checks++; if (led !== exp_led) begin n_fail++; $display("FAIL add_led: got %b required %b", led, exp_led); end
    n_checks++; if (pc !== 4'd1)     begin n_fail++; $display("FAIL add_pc: got %0d required 1", pc); end
    n_checks++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL add_busy_halt: got %b required 0", busy); end
    @(posedge fast_clk); #1;
    n_checks++; if (done !== 1'b0)   begin n_fail++; $display("FAIL add_done_pulse: got %b required 0", done); end
    n_checks++; if (res !== 8'h08)   begin n_fail++; $display("FAIL add_res_hold: got %h required 08", res); end
  endtask

  task automatic test_sub();
    int cyc;
    load(0, ins(5'd2, 8'h03, 8'h05));
    run(cyc);
    exp_led = ~exp_led;
    n_checks++; if (cyc !== 6)        begin n_fail++; $display("FAIL sub_cycles: got %0d required 6", cyc); end
    n_checks++; if (res !== 8'hFE)    begin n_fail++; $display("FAIL sub_res: got %h required fe", res); end
    n_checks++; if (flags !== 3'b110) begin n_fail++; $display("FAIL sub_flags: got %b required 110", flags); end
    n_checks++; if (led !== exp_led)  begin n_fail++; $display("FAIL sub_led: got %b required %b", led, exp_led); end
  endtask

  task automatic test_jz();
    int cyc;
    load(0, ins(5'd9, 8'h07, 8'h07));
    load(1, ins(5'd11, 8'h03, 8'h00));
    load(2, ins(5'd1, 8'h01, 8'h01));
    load(3, ins(5'd31, 8'h00, 8'h00));
    run(cyc);
    exp_led = ~exp_led;
    n_checks++; if (cyc !== 9)        begin n_fail++; $display("FAIL jz_cycles: got %0d required 9", cyc); end
    n_checks++; if (res !== 8'h00)    begin n_fail++; $display("FAIL jz_res: got %h required 00", res); end
    n_checks++; if (flags !== 3'b001) begin n_fail++; $display("FAIL jz_flags: got %b required 001", flags); end
    n_checks++; if (steps !== 8'd3)   begin n_fail++; $display("FAIL jz_steps: got %0d required 3", steps); end
    n_checks++; if (pc !== 4'd3)      begin n_fail++; $display("FAIL jz_pc: got %0d required 3", pc); end
  endtask

  task automatic test_watchdog();
    int cyc;
    load(0, ins(5'd10, 8'h01, 8'h00));
    load(1, ins(5'd13, 8'h00, 8'h00));
    run(cyc);
    exp_led = ~exp_led;
    n_checks++; if (cyc !== 30)       begin n_fail++; $display("FAIL wd_cycles: got %0d required 30", cyc); end
    n_checks++; if (err !== 2'd2)     begin n_fail++; $display("FAIL wd_err: got %0d required 2", err); end
    n_checks++; if (steps !== 8'd10)  begin n_fail++; $display("FAIL wd_steps: got %0d required 10", steps); end
    n_checks++; if (res !== 8'h05)    begin n_fail++; $display("FAIL wd_res: got %h required 05", res); end
    n_checks++; if (flags !== 3'b000) begin n_fail++; $display("FAIL wd_flags: got %b required 000", flags); end
  endtask

  task automatic test_illegal();
    int cyc;
    load(0, ins(5'd20, 8'h00, 8'h00));
    run(cyc);
    exp_led = ~exp_led;
    n_checks++; if (cyc !== 2)        begin n_fail++; $display("FAIL ill_cycles: got %0d required 2", cyc); end
    n_checks++; if (err !== 2'd1)     begin n_fail++; $display("FAIL ill_err: got %0d required 1", err); end
    n_checks++; if (res !== 8'h00)    begin n_fail++; $display("FAIL ill_res: got %h required 00", res); end
    n_checks++; if (flags !== 3'b000) begin n_fail++; $display("FAIL ill_flags: got %b required 000", flags); end
    n_checks++; if (steps !== 8'd0)   begin n_fail++; $display("FAIL ill_steps: got %0d required 0", steps); end
    n_checks++; if (led !== exp_led)  begin n_fail++; $display("FAIL ill_led: got %b required %b", led, exp_led); end
  endtask

  task automatic test_we_while_busy();
    int cyc;
    load(0, ins(5'd1, 8'h05, 8'h03));
    load(1, ins(5'd31, 8'h00, 8'h00));
    start = 1'b1;
    @(posedge fast_clk); #1;
    start = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_after_start: got %b required 1", busy); end
    prog_we = 1'b1; prog_addr = 4'd0; prog_data = ins(5'd20, 8'h00, 8'h00);
    @(posedge fast_clk); #1;
    prog_we = 1'b0;
    cyc = -1;
    for (int i = 2; i <= 200; i++) begin
      @(posedge fast_clk); #1;
      if (done === 1'b1) begin cyc = i; break; end
    end
    exp_led = ~exp_led;
    n_checks++; if (cyc !== 6) begin n_fail++; $display("FAIL busy_run_cycles: got %0d required 6", cyc); end
    run(cyc);
    exp_led = ~exp_led;
    n_checks++; if (cyc !== 6)      begin n_fail++; $display("FAIL rerun_cycles: got %0d required 6", cyc); end
    n_checks++; if (err !== 2'd0)   begin n_fail++; $display("FAIL rerun_err: got %0d required 0", err); end
    n_checks++; if (res !== 8'h08)  begin n_fail++; $display("FAIL rerun_res: got %h required 08", res); end
  endtask

  task automatic test_we_with_start();
    int cyc;
    prog_we = 1'b1; prog_addr = 4'd0; prog_data = ins(5'd1, 8'h02, 8'h02);
    start = 1'b1;
    @(posedge fast_clk); #1;
    prog_we = 1'b0; start = 1'b0;
    cyc = -1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge fast_clk); #1;
      if (done === 1'b1) begin cyc = i; break; end
    end
    exp_led = ~exp_led;
    n_checks++; if (cyc !== 6)      begin n_fail++; $display("FAIL wes_cycles: got %0d required 6", cyc); end
    n_checks++; if (res !== 8'h04)  begin n_fail++; $display("FAIL wes_res: got %h required 04", res); end
  endtask

  task automatic test_reset_mid_run();
    int   cyc;
    logic saw_done;
    load(0, ins(5'd1, 8'h05, 8'h03));
    start = 1'b1;
    @(posedge fast_clk); #1;
    start = 1'b0;
    @(posedge fast_clk); #1;
    n_checks++; if (opcode !== 5'd1) begin n_fail++; $display("FAIL mid_opcode_exec: got %0d required 1", opcode); end
    rst = 1'b1;
    #1;
    n_checks++; if ({pc, in_a, in_b, opcode, res, flags, steps, err, busy, done, led} !== '0) begin n_fail++; $display("FAIL mid_reset_outputs: got %h required 0", {pc, in_a, in_b, opcode, res, flags, steps, err, busy, done, led}); end
    saw_done = 1'b0;
    repeat (2) begin @(posedge fast_clk); #1; if (done !== 1'b0) saw_done = 1'b1; end
    rst = 1'b0;
    repeat (3) begin @(posedge fast_clk); #1; if (done !== 1'b0) saw_done = 1'b1; end
    n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL mid_no_done: got %b required 0", saw_done); end
    exp_led = 1'b0;
    run(cyc);
    exp_led = ~exp_led;
    n_checks++; if (cyc !== 6)       begin n_fail++; $display("FAIL restart_cycles: got %0d required 6", cyc); end
    n_checks++; if (res !== 8'h08)   begin n_fail++; $display("FAIL restart_res: got %h required 08", res); end
    n_checks++; if (steps !== 8'd2)  begin n_fail++; $display("FAIL restart_steps: got %0d required 2", steps); end
    n_checks++; if (led !== exp_led) begin n_fail++; $display("FAIL restart_led: got %b required %b", led, exp_led); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_jz();
    test_watchdog();
    test_illegal();
    test_we_while_busy();
    test_we_with_start();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/prog_alu_sequencer.md
Name: prog_alu_sequencer

Overview:
Parametrised successor to the fixed 2-bit ALU plus sequencer pair. It holds a small loadable program memory and steps through it with a fetch/execute/writeback FSM. Each instruction drives a WIDTH-bit ALU, and results accumulate in an internal register with zero, carry and negative flags. The block adds conditional and unconditional jumps, halt, illegal-opcode detection and a step watchdog, and exposes ALU operands and results for board LEDs and debug.

Parameters:
WIDTH, 8, ALU operand/result width (>=2)
DEPTH, 16, program memory words (power of 2, >=2)
MAX_STEPS, 255, watchdog: max executed instructions per run (>=1)

Ports:
fast_clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
prog_we  in  1  program write strobe (honoured only in IDLE/HALT)
prog_addr  in  $clog2(DEPTH)  program write address
prog_data  in  5+2*WIDTH  instruction word {opcode[4:0], opa[WIDTH-1:0], opb[WIDTH-1:0]}
start  in  1  one-cycle pulse: begin run at pc=0
busy  out  1  high from the cycle after an accepted start until HALT
done  out  1  one-cycle pulse on entry to HALT
err  out  2  0=normal halt, 1=illegal opcode, 2=watchdog timeout
pc  out  $clog2(DEPTH)  current program counter
in_a, in_b  out  WIDTH  ALU operands of the current instruction
opcode  out  5  current opcode
res  out  WIDTH  accumulator (last written result)
flags  out  3  {N,C,Z} from the last flag-writing instruction
steps  out  8  executed-instruction count, saturates at 255
led  out  1  toggles on every done pulse

Behaviour:
- Reset (async, any state): state=IDLE, pc=0, in_a=in_b=0, opcode=0, res=0, flags=0, steps=0, err=0, busy=0, done=0, led=0. Program memory is not reset; contents survive.
- States: IDLE -> FETCH (on start) -> EXEC -> WB -> FETCH ... -> HALT. HALT -> FETCH on start. Each instruction takes exactly 3 cycles.
- start is accepted only in IDLE/HALT. An accepted start clears pc, res, flags, steps and err. start is ignored while busy.
- prog_we is ignored while busy. A same-cycle prog_we and start in IDLE/HALT: the write happens and the run starts; the first fetch sees the new word.
- FETCH: latches opcode, in_a=opa, in_b=opb from mem[pc].
- EXEC: combinational ALU, result registered into a temp.
  - 0 NOP
  - 1 ADD a+b
  - 2 SUB a-b (C=borrow)
  - 3 AND
  - 4 OR
  - 5 XOR
  - 6 NOT a
  - 7 SHL a by b[2:0] (C=last bit out)
  - 8 SHR logical
  - 9 CMP (a-b, flags only)
  - 10 ACC res+a
  - 11 JZ to opa[$clog2(DEPTH)-1:0] if Z
  - 12 JNZ
  - 13 JMP
  - 31 HALT
  - any other opcode: illegal, err=1, go to HALT with no writeback.
- WB: ops 1-8 and 10 write res and {N,C,Z}. Z=(result==0), N=result MSB, C=carry/borrow out of WIDTH bits. NOT, AND, OR and XOR clear C. Jumps and NOP leave res and flags unchanged. Taken jump sets pc=target; otherwise pc=pc+1, wrapping DEPTH-1 -> 0 without error. steps increments (saturating).
- Watchdog: if steps reaches MAX_STEPS at WB of a non-HALT instruction, go to HALT with err=2.
- HALT (opcode 31 or error): busy=0, done pulses one cycle, led toggles. res, flags, pc and steps hold until the next start or reset.
- Reset mid-run aborts immediately with no done pulse and no led toggle.

Test Plan:
- Load [0]={1,0x05,0x03}, [1]={31,0,0}; start -> done after 6 cycles, res=0x08, flags=000, err=0, steps=2, led=1.
- [0]={2,0x03,0x05}, [1]=HALT -> res=0xFE, flags N=1, C=1, Z=0.
- [0]={9,0x07,0x07}, [1]={11,0x03,0}, [2]={1,1,1}, [3]=HALT -> JZ taken, res=0x00, Z=1, steps=3, pc=3 at halt.
- Loop [0]={10,0x01,0}, [1]={13,0x00,0} with MAX_STEPS=10 -> err=2, steps=10, res=0x05.
- [0]={20,0,0} -> err=1 after 2 cycles, res and flags unchanged (0). A prog_we issued while busy in another run leaves memory unchanged (verify by rerun).
- Assert rst during EXEC of an ADD -> all outputs zero the same cycle, no done pulse. Restart without reloading -> same result as the first test (memory retained).
